// File: rtl/point_link_pkg.sv
// Shared definitions for the point-position link: frame framing constants,
// byte-state encoding and coordinate width, common to transmitter and decoder.
package point_link_pkg;

    localparam logic [7:0] LINK_HEADER = 8'hA5;
    localparam int         FRAME_LEN   = 6;
    localparam int         COORD_W     = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XH,
        ST_XL,
        ST_YH,
        ST_YL,
        ST_CHK
    } frame_state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] xh, input logic [7:0] xl,
                                             input logic [7:0] yh, input logic [7:0] yl);
        return xh ^ xl ^ yh ^ yl;
    endfunction

endpackage

// File: rtl/point_frame_fsm.sv
// Byte-level frame parser: walks HDR/XH/XL/YH/YL/CHK, checks checksum, range
// and inter-byte timeout, and emits a one-cycle accept or error pulse.
module point_frame_fsm
    import point_link_pkg::*;
#(
    parameter logic [7:0] HEADER         = LINK_HEADER,
    parameter int         X_MAX          = 799,
    parameter int         Y_MAX          = 599,
    parameter int         TIMEOUT_CYCLES = 400_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_valid_i,
    output logic               accept_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               err_o
);

    localparam int                 CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);
    localparam logic [CNT_W-1:0]   T_END = CNT_W'(TIMEOUT_CYCLES - 1);

    frame_state_t       state_q;
    logic [7:0]         acc_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept_q;
    logic               err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            accept_q <= 1'b0;
            err_q    <= 1'b0;
            if (rx_valid_i) begin
                cnt_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data_i == HEADER) begin
                            state_q <= ST_XH;
                            acc_q   <= '0;
                        end
                    end
                    ST_XH: begin
                        if (rx_data_i[7:2] != 6'd0) begin
                            state_q <= ST_IDLE;
                            err_q   <= 1'b1;
                        end else begin
                            x_q[9:8] <= rx_data_i[1:0];
                            acc_q    <= acc_q ^ rx_data_i;
                            state_q  <= ST_XL;
                        end
                    end
                    ST_XL: begin
                        x_q[7:0] <= rx_data_i;
                        acc_q    <= acc_q ^ rx_data_i;
                        state_q  <= ST_YH;
                    end
                    ST_YH: begin
                        if (rx_data_i[7:2] != 6'd0) begin
                            state_q <= ST_IDLE;
                            err_q   <= 1'b1;
                        end else begin
                            y_q[9:8] <= rx_data_i[1:0];
                            acc_q    <= acc_q ^ rx_data_i;
                            state_q  <= ST_YL;
                        end
                    end
                    ST_YL: begin
                        y_q[7:0] <= rx_data_i;
                        acc_q    <= acc_q ^ rx_data_i;
                        state_q  <= ST_CHK;
                    end
                    ST_CHK: begin
                        state_q <= ST_IDLE;
                        if (rx_data_i == acc_q && x_q <= X_LIM && y_q <= Y_LIM)
                            accept_q <= 1'b1;
                        else
                            err_q <= 1'b1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q == ST_IDLE) begin
                cnt_q <= '0;
            end else if (cnt_q == T_END) begin
                // Stalled mid-frame: abandon it so the next header can resync.
                state_q <= ST_IDLE;
                err_q   <= 1'b1;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Shadow x/y only change on XH..YL bytes, so they are stable while accept is high.
    assign accept_o = accept_q;
    assign err_o    = err_q;
    assign x_o      = x_q;
    assign y_o      = y_q;

endmodule

// File: rtl/point_2_rx_decoder.sv
// Point-position receiver: parses frames and commits the latest accepted
// position to the overlay outputs only on a vblank rising edge.
module point_2_rx_decoder
    import point_link_pkg::*;
#(
    parameter int X_MAX          = 799,
    parameter int Y_MAX          = 599,
    parameter int X_RST          = 400,
    parameter int Y_RST          = 300,
    parameter int TIMEOUT_CYCLES = 400_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         vblnk,
    output logic [9:0]   point_x_2,
    output logic [9:0]   point_y_2,
    output logic         point_valid,
    output logic         frame_err
);

    logic               accept;
    logic [COORD_W-1:0] fr_x;
    logic [COORD_W-1:0] fr_y;
    logic               fr_err;

    point_frame_fsm #(
        .HEADER        (LINK_HEADER),
        .X_MAX         (X_MAX),
        .Y_MAX         (Y_MAX),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .rx_data_i (rx_data),
        .rx_valid_i(rx_valid),
        .accept_o  (accept),
        .x_o       (fr_x),
        .y_o       (fr_y),
        .err_o     (fr_err)
    );

    logic               vblnk_q;
    logic               pend_q;
    logic [COORD_W-1:0] pend_x_q;
    logic [COORD_W-1:0] pend_y_q;
    logic [COORD_W-1:0] px_q;
    logic [COORD_W-1:0] py_q;
    logic               pvalid_q;
    logic               commit_d;

    assign commit_d = vblnk & ~vblnk_q & pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_q  <= 1'b0;
            pend_q   <= 1'b0;
            pend_x_q <= '0;
            pend_y_q <= '0;
            px_q     <= COORD_W'(X_RST);
            py_q     <= COORD_W'(Y_RST);
            pvalid_q <= 1'b0;
        end else begin
            vblnk_q <= vblnk;
            if (commit_d) begin
                px_q     <= pend_x_q;
                py_q     <= pend_y_q;
                pvalid_q <= 1'b1;
            end
            // A fresh accept wins over the commit clearing pending.
            if (accept) begin
                pend_x_q <= fr_x;
                pend_y_q <= fr_y;
                pend_q   <= 1'b1;
            end else if (commit_d) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign point_x_2   = px_q;
    assign point_y_2   = py_q;
    assign point_valid = pvalid_q;
    assign frame_err   = fr_err;

endmodule

// File: tb/tb_point_2_rx_decoder.sv
// Bench for point_2_rx_decoder: directed frames plus randomized frame traffic
// against a frame-level reference model of accept/commit/error behaviour.
module tb_point_2_rx_decoder;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       vblnk = 1'b0;
    logic [9:0] point_x_2;
    logic [9:0] point_y_2;
    logic       point_valid;
    logic       frame_err;

    point_2_rx_decoder #(
        .X_MAX(799), .Y_MAX(599), .X_RST(400), .Y_RST(300), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .vblnk      (vblnk),
        .point_x_2  (point_x_2),
        .point_y_2  (point_y_2),
        .point_valid(point_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Error pulse monitor, sampled on the falling edge.
    int   err_seen = 0;
    int   err_overlap = 0;
    logic err_prev = 1'b0;
    always @(negedge clk) begin
        if (frame_err) err_seen++;
        if (frame_err && err_prev) err_overlap++;
        err_prev = frame_err;
    end

    // Reference model state.
    logic [9:0] m_x = 10'd400, m_y = 10'd300;
    logic       m_valid = 1'b0;
    logic       m_pend = 1'b0;
    logic [9:0] m_px = '0, m_py = '0;
    int         m_err = 0;

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input int x, input int y, input logic bad_chk, input int maxgap);
        logic [7:0] xh, xl, yh, yl, chk;
        xh  = 8'((x >> 8) & 3);
        xl  = 8'(x & 255);
        yh  = 8'((y >> 8) & 3);
        yl  = 8'(y & 255);
        chk = xh ^ xl ^ yh ^ yl;
        if (bad_chk) chk = chk ^ 8'($urandom_range(255, 1));
        send_byte(8'hA5, $urandom_range(maxgap, 0));
        send_byte(xh, $urandom_range(maxgap, 0));
        send_byte(xl, $urandom_range(maxgap, 0));
        send_byte(yh, $urandom_range(maxgap, 0));
        send_byte(yl, $urandom_range(maxgap, 0));
        send_byte(chk, 0);
        if (!bad_chk && x <= 799 && y <= 599) begin
            m_pend = 1'b1;
            m_px   = 10'(x);
            m_py   = 10'(y);
        end else begin
            m_err++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_vblank();
        @(negedge clk);
        vblnk = 1'b1;
        if (m_pend) begin
            m_x = m_px; m_y = m_py; m_valid = 1'b1; m_pend = 1'b0;
        end
        repeat (3) @(negedge clk);
        vblnk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if ({point_valid, point_x_2, point_y_2, frame_err} !== {1'b0, 10'd400, 10'd300, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%0b x=%0d y=%0d err=%0b, want v=0 x=400 y=300 err=0",
                     point_valid, point_x_2, point_y_2, frame_err);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bad_chk();
        int e0;
        e0 = err_seen;
        send_byte(8'hA5, 0); send_byte(8'h01, 1); send_byte(8'h2C, 0);
        send_byte(8'h00, 2); send_byte(8'hC8, 0); send_byte(8'hE4, 0);
        m_err++;
        repeat (3) @(negedge clk);
        tests_run++;
        if (err_seen - e0 !== 1) begin
            tests_failed++;
            $display("FAIL bad_chk_err: got %0d pulses, want 1", err_seen - e0);
        end
        pulse_vblank();
        tests_run++;
        if ({point_valid, point_x_2, point_y_2} !== {1'b0, 10'd400, 10'd300}) begin
            tests_failed++;
            $display("FAIL bad_chk_nocommit: got v=%0b x=%0d y=%0d, want v=0 x=400 y=300",
                     point_valid, point_x_2, point_y_2);
        end
    endtask

    task automatic test_basic();
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h2C, 0);
        send_byte(8'h00, 0); send_byte(8'hC8, 0); send_byte(8'hE5, 0);
        repeat (3) @(negedge clk);
        tests_run++;
        if ({point_valid, point_x_2, point_y_2} !== {1'b0, 10'd400, 10'd300}) begin
            tests_failed++;
            $display("FAIL basic_before_vblank: got v=%0b x=%0d y=%0d, want v=0 x=400 y=300",
                     point_valid, point_x_2, point_y_2);
        end
        @(negedge clk);
        vblnk = 1'b1;
        #1;
        tests_run++;
        if ({point_valid, point_x_2, point_y_2} !== {1'b0, 10'd400, 10'd300}) begin
            tests_failed++;
            $display("FAIL basic_edge_cycle: got v=%0b x=%0d y=%0d, want v=0 x=400 y=300",
                     point_valid, point_x_2, point_y_2);
        end
        @(negedge clk);
        tests_run++;
        if ({point_valid, point_x_2, point_y_2} !== {1'b1, 10'd300, 10'd200}) begin
            tests_failed++;
            $display("FAIL basic_commit: got v=%0b x=%0d y=%0d, want v=1 x=300 y=200",
                     point_valid, point_x_2, point_y_2);
        end
        repeat (2) @(negedge clk);
        vblnk = 1'b0;
        repeat (2) @(negedge clk);
        m_x = 10'd300; m_y = 10'd200; m_valid = 1'b1;
    endtask

    task automatic test_overwrite();
        send_frame(300, 200, 1'b0, 2);
        send_frame(10, 20, 1'b0, 2);
        pulse_vblank();
        tests_run++;
        if ({point_valid, point_x_2, point_y_2} !== {1'b1, 10'd10, 10'd20}) begin
            tests_failed++;
            $display("FAIL overwrite: got v=%0b x=%0d y=%0d, want v=1 x=10 y=20",
                     point_valid, point_x_2, point_y_2);
        end
    endtask

    task automatic test_range();
        int e0;
        e0 = err_seen;
        send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h20, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h23, 0);
        m_err++;
        repeat (3) @(negedge clk);
        tests_run++;
        if (err_seen - e0 !== 1) begin
            tests_failed++;
            $display("FAIL range_err: got %0d pulses, want 1", err_seen - e0);
        end
        pulse_vblank();
        tests_run++;
        if ({point_valid, point_x_2, point_y_2} !== {1'b1, 10'd10, 10'd20}) begin
            tests_failed++;
            $display("FAIL range_nocommit: got v=%0b x=%0d y=%0d, want v=1 x=10 y=20",
                     point_valid, point_x_2, point_y_2);
        end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_seen;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        repeat (TO - 10) @(negedge clk);
        tests_run++;
        if (err_seen !== e0) begin
            tests_failed++;
            $display("FAIL timeout_early: got %0d pulses, want 0", err_seen - e0);
        end
        repeat (15) @(negedge clk);
        m_err++;
        tests_run++;
        if (err_seen - e0 !== 1) begin
            tests_failed++;
            $display("FAIL timeout_err: got %0d pulses, want 1", err_seen - e0);
        end
        send_frame(555, 444, 1'b0, 1);
        pulse_vblank();
        tests_run++;
        if ({point_valid, point_x_2, point_y_2} !== {1'b1, 10'd555, 10'd444}) begin
            tests_failed++;
            $display("FAIL timeout_recover: got v=%0b x=%0d y=%0d, want v=1 x=555 y=444",
                     point_valid, point_x_2, point_y_2);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int kind;
            if ($urandom_range(3, 0) == 0) send_byte(8'($urandom_range(164, 0)), 0);
            kind = $urandom_range(7, 0);
            if (kind == 0) begin
                send_byte(8'hA5, 0);
                send_byte(8'(4 << $urandom_range(5, 0)) | 8'($urandom_range(3, 0)), 0);
                m_err++;
                repeat (3) @(negedge clk);
            end else begin
                send_frame($urandom_range(1023, 0), $urandom_range(1023, 0),
                           (kind == 1), 3);
            end
            tests_run++;
            if (err_seen !== m_err) begin
                tests_failed++;
                $display("FAIL random_err[%0d]: got %0d pulses, want %0d", i, err_seen, m_err);
            end
            if ($urandom_range(1, 0) == 1) begin
                pulse_vblank();
                tests_run++;
                if ({point_valid, point_x_2, point_y_2} !== {m_valid, m_x, m_y}) begin
                    tests_failed++;
                    $display("FAIL random_out[%0d]: got v=%0b x=%0d y=%0d, want v=%0b x=%0d y=%0d",
                             i, point_valid, point_x_2, point_y_2, m_valid, m_x, m_y);
                end
            end
        end
        tests_run++;
        if (err_overlap !== 0) begin
            tests_failed++;
            $display("FAIL err_overlap: got %0d back-to-back pulses, want 0", err_overlap);
        end
    endtask

    task automatic test_reset_midframe();
        int e0;
        send_frame(123, 456, 1'b0, 1);
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h07, 0); send_byte(8'h01, 0);
        e0 = err_seen;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({point_valid, point_x_2, point_y_2} !== {1'b0, 10'd400, 10'd300}) begin
            tests_failed++;
            $display("FAIL rst_async: got v=%0b x=%0d y=%0d, want v=0 x=400 y=300",
                     point_valid, point_x_2, point_y_2);
        end
        m_x = 10'd400; m_y = 10'd300; m_valid = 1'b0; m_pend = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_byte(8'h10, 0);
        pulse_vblank();
        tests_run++;
        if ({point_valid, point_x_2, point_y_2} !== {1'b0, 10'd400, 10'd300}) begin
            tests_failed++;
            $display("FAIL rst_nocommit: got v=%0b x=%0d y=%0d, want v=0 x=400 y=300",
                     point_valid, point_x_2, point_y_2);
        end
        tests_run++;
        if (err_seen !== e0) begin
            tests_failed++;
            $display("FAIL rst_noerr: got %0d pulses, want 0", err_seen - e0);
        end
    endtask

    initial begin
        test_reset();
        test_bad_chk();
        test_basic();
        test_overwrite();
        test_range();
        test_timeout();
        test_random();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
